// File: rtl/seg7_scan_decoder.sv
// Recovers BCD digits and decimal points from a multiplexed 7-segment bus.
// Each (select, pattern, polarity) sample must repeat STABLE_CYCLES times before it is committed.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   sel_in,
  input  logic                    inv,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic [NUM_DIGITS-1:0]   valid,
  output logic                    upd_stb,
  output logic [2:0]              upd_idx,
  output logic                    err
);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

  localparam logic [3:0] STABLE_C = 4'(STABLE_CYCLES);

  // Returns {known_digit, blank, value}.
  function automatic logic [5:0] decode7(input logic [6:0] p);
    case (p)
      7'b0111111: decode7 = {2'b10, 4'd0};
      7'b0000110: decode7 = {2'b10, 4'd1};
      7'b1011011: decode7 = {2'b10, 4'd2};
      7'b1001111: decode7 = {2'b10, 4'd3};
      7'b1100110: decode7 = {2'b10, 4'd4};
      7'b1101101: decode7 = {2'b10, 4'd5};
      7'b1111101: decode7 = {2'b10, 4'd6};
      7'b0000111: decode7 = {2'b10, 4'd7};
      7'b1111111: decode7 = {2'b10, 4'd8};
      7'b1101111: decode7 = {2'b10, 4'd9};
      7'b0000000: decode7 = {2'b01, 4'hF};
      default:    decode7 = {2'b00, 4'hF};
    endcase
  endfunction

  logic [7:0]              seg_q;
  logic [NUM_DIGITS-1:0]   sel_q;
  logic                    inv_q;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [7:0]              cand_seg_q, cand_seg_d;
  logic [NUM_DIGITS-1:0]   cand_sel_q, cand_sel_d;
  logic                    cand_inv_q, cand_inv_d;

  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic                    upd_stb_q, upd_stb_d;
  logic [2:0]              upd_idx_q, upd_idx_d;
  logic                    err_q, err_d;

  logic [3:0]              sel_ones;
  logic [2:0]              sel_idx;
  logic                    is_idle, is_digit, is_illegal, match;
  logic [7:0]              lit;
  logic [5:0]              dec;
  logic                    take, commit, illegal_err;

  // Input stage: single register, then classify the registered sample
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= '0;
      sel_q <= '0;
      inv_q <= 1'b0;
    end else begin
      seg_q <= seg_in;
      sel_q <= sel_in;
      inv_q <= inv;
    end
  end

  always_comb begin
    sel_ones = '0;
    sel_idx  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_q[i]) begin
        sel_ones = sel_ones + 4'd1;
        sel_idx  = 3'(i);
      end
    end
  end

  assign is_idle    = (sel_q == '0);
  assign is_digit   = (sel_ones == 4'd1);
  assign is_illegal = !is_idle && !is_digit;
  assign match      = (sel_q == cand_sel_q) && (seg_q == cand_seg_q) && (inv_q == cand_inv_q);
  assign lit        = inv_q ? seg_q : ~seg_q;
  assign dec        = decode7(lit[6:0]);

  // Stability tracker
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_seg_d  = cand_seg_q;
    cand_sel_d  = cand_sel_q;
    cand_inv_d  = cand_inv_q;
    take        = 1'b0;
    commit      = 1'b0;
    illegal_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_digit)        take        = 1'b1;
        else if (is_illegal) illegal_err = 1'b1;
      end
      TRACK, LOCKED: begin
        if (match) begin
          if (state_q == TRACK) begin
            if (cnt_q + 4'd1 == STABLE_C) begin
              cnt_d   = STABLE_C;
              commit  = 1'b1;
              state_d = LOCKED;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end else if (is_digit) begin
          take = 1'b1;
        end else begin
          illegal_err = is_illegal;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      cand_seg_d = seg_q;
      cand_sel_d = sel_q;
      cand_inv_d = inv_q;
      cnt_d      = 4'd1;
      if (STABLE_C == 4'd1) begin
        commit  = 1'b1;
        state_d = LOCKED;
      end else begin
        state_d = TRACK;
      end
    end
  end

  // Commit into the per-digit output registers
  always_comb begin
    bcd_d     = bcd_q;
    dp_d      = dp_q;
    valid_d   = valid_q;
    upd_stb_d = 1'b0;
    upd_idx_d = upd_idx_q;
    err_d     = illegal_err;
    if (commit) begin
      if (dec[5] || dec[4]) begin
        upd_stb_d = 1'b1;
        upd_idx_d = sel_idx;
      end else begin
        err_d = 1'b1;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (sel_idx == 3'(i)) begin
          valid_d[i] = dec[5];
          if (dec[5] || dec[4]) begin
            bcd_d[4*i +: 4] = dec[3:0];
            dp_d[i]         = lit[7];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cand_seg_q <= '0;
      cand_sel_q <= '0;
      cand_inv_q <= 1'b0;
      bcd_q      <= '1;
      dp_q       <= '0;
      valid_q    <= '0;
      upd_stb_q  <= 1'b0;
      upd_idx_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_seg_q <= cand_seg_d;
      cand_sel_q <= cand_sel_d;
      cand_inv_q <= cand_inv_d;
      bcd_q      <= bcd_d;
      dp_q       <= dp_d;
      valid_q    <= valid_d;
      upd_stb_q  <= upd_stb_d;
      upd_idx_q  <= upd_idx_d;
      err_q      <= err_d;
    end
  end

  assign bcd_out = bcd_q;
  assign dp_out  = dp_q;
  assign valid   = valid_q;
  assign upd_stb = upd_stb_q;
  assign upd_idx = upd_idx_q;
  assign err     = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg_in;
  logic [3:0]  sel_in;
  logic        inv;
  logic [15:0] bcd_out;
  logic [3:0]  dp_out;
  logic [3:0]  valid;
  logic        upd_stb;
  logic [2:0]  upd_idx;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] scan_seg [4] = '{8'b00000110, 8'b01111111, 8'b11101101, 8'b00000000};

  seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .sel_in(sel_in), .inv(inv),
    .bcd_out(bcd_out), .dp_out(dp_out), .valid(valid),
    .upd_stb(upd_stb), .upd_idx(upd_idx), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle(input int n);
    sel_in = 4'b0000;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; sel_in = '0; seg_in = 8'hFF; inv = 1'b0;
    tick(); tick();
    n_cmp++; if (bcd_out !== 16'hFFFF) begin n_bad++; $display("FAIL reset_bcd got=%h exp=ffff", bcd_out); end
    n_cmp++; if (valid !== 4'b0000) begin n_bad++; $display("FAIL reset_valid got=%b exp=0000", valid); end
    n_cmp++; if ({upd_stb, err, dp_out, upd_idx} !== 9'b0) begin n_bad++; $display("FAIL reset_ctrl got=%b exp=0", {upd_stb, err, dp_out, upd_idx}); end
    rst = 1'b0;
  endtask

  task automatic test_single_digit();
    int pulses = 0;
    inv = 1'b0; sel_in = 4'b0010; seg_in = 8'b10100100;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (upd_stb === 1'b1) pulses++;
      if (c == 5) begin
        n_cmp++; if (upd_stb !== 1'b1 || upd_idx !== 3'd1) begin n_bad++; $display("FAIL single_stb got=%b/%0d exp=1/1", upd_stb, upd_idx); end
      end
    end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL single_pulses got=%0d exp=1", pulses); end
    n_cmp++; if (bcd_out !== 16'hFF2F) begin n_bad++; $display("FAIL single_bcd got=%h exp=ff2f", bcd_out); end
    n_cmp++; if (valid !== 4'b0010 || dp_out !== 4'b0000) begin n_bad++; $display("FAIL single_vld_dp got=%b/%b exp=0010/0000", valid, dp_out); end
    go_idle(2);
  endtask

  task automatic test_glitch_filter();
    int pulses = 0;
    int errs = 0;
    inv = 1'b0; sel_in = 4'b0010; seg_in = 8'b10100100;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 3) seg_in = 8'b10010000;
      if (upd_stb === 1'b1) pulses++;
      if (err === 1'b1) errs++;
      if (c == 8) begin
        n_cmp++; if (upd_stb !== 1'b1) begin n_bad++; $display("FAIL glitch_stb_edge8 got=%b exp=1", upd_stb); end
      end
    end
    n_cmp++; if (pulses != 1 || errs != 0) begin n_bad++; $display("FAIL glitch_pulses got=%0d/%0d exp=1/0", pulses, errs); end
    n_cmp++; if (bcd_out !== 16'hFF9F || valid !== 4'b0010) begin n_bad++; $display("FAIL glitch_bcd got=%h/%b exp=ff9f/0010", bcd_out, valid); end
    go_idle(2);
  endtask

  task automatic test_scan_loop();
    inv = 1'b1;
    for (int d = 0; d < 4; d++) begin
      sel_in = 4'b0001 << d; seg_in = scan_seg[d];
      repeat (5) tick();
      n_cmp++; if (upd_stb !== 1'b1 || upd_idx !== 3'(d)) begin n_bad++; $display("FAIL scan_stb_d%0d got=%b/%0d exp=1/%0d", d, upd_stb, upd_idx, d); end
      go_idle(1);
    end
    n_cmp++; if (bcd_out !== 16'hF581) begin n_bad++; $display("FAIL scan_bcd got=%h exp=f581", bcd_out); end
    n_cmp++; if (valid !== 4'b0111) begin n_bad++; $display("FAIL scan_valid got=%b exp=0111", valid); end
    n_cmp++; if (dp_out !== 4'b0100) begin n_bad++; $display("FAIL scan_dp got=%b exp=0100", dp_out); end
    go_idle(1);
  endtask

  task automatic test_errors();
    int errs = 0;
    int ups = 0;
    sel_in = 4'b0110; seg_in = 8'b01111111;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) sel_in = 4'b0000;
      if (err === 1'b1) errs++;
      if (c == 2) begin
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL multihot_err got=%b exp=1", err); end
      end
    end
    n_cmp++; if (errs != 1) begin n_bad++; $display("FAIL multihot_count got=%0d exp=1", errs); end
    n_cmp++; if (bcd_out !== 16'hF581 || valid !== 4'b0111) begin n_bad++; $display("FAIL multihot_fields got=%h/%b exp=f581/0111", bcd_out, valid); end
    errs = 0;
    inv = 1'b1; sel_in = 4'b0001; seg_in = 8'b00001001;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (err === 1'b1) errs++;
      if (upd_stb === 1'b1) ups++;
      if (c == 5) begin
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL unrec_err got=%b exp=1", err); end
      end
    end
    n_cmp++; if (errs != 1 || ups != 0) begin n_bad++; $display("FAIL unrec_pulses got=%0d/%0d exp=1/0", errs, ups); end
    n_cmp++; if (bcd_out !== 16'hF581 || valid !== 4'b0110 || dp_out !== 4'b0100) begin n_bad++; $display("FAIL unrec_fields got=%h/%b/%b exp=f581/0110/0100", bcd_out, valid, dp_out); end
    go_idle(2);
  endtask

  task automatic test_reset_mid_track();
    int early = 0;
    inv = 1'b1; sel_in = 4'b0100; seg_in = 8'b01111111;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (bcd_out !== 16'hFFFF || valid !== 4'b0000 || dp_out !== 4'b0000) begin n_bad++; $display("FAIL midrst_fields got=%h/%b/%b exp=ffff/0000/0000", bcd_out, valid, dp_out); end
    n_cmp++; if (upd_stb !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL midrst_pulses got=%b/%b exp=0/0", upd_stb, err); end
    rst = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c <= 4 && upd_stb === 1'b1) early++;
      if (c == 5) begin
        n_cmp++; if (upd_stb !== 1'b1 || upd_idx !== 3'd2) begin n_bad++; $display("FAIL midrst_commit got=%b/%0d exp=1/2", upd_stb, upd_idx); end
      end
    end
    n_cmp++; if (early != 0) begin n_bad++; $display("FAIL midrst_early got=%0d exp=0", early); end
    n_cmp++; if (bcd_out !== 16'hF8FF || valid !== 4'b0100) begin n_bad++; $display("FAIL midrst_bcd got=%h/%b exp=f8ff/0100", bcd_out, valid); end
    go_idle(2);
  endtask

  initial begin
    test_reset();
    test_single_digit();
    test_glitch_filter();
    test_scan_loop();
    test_errors();
    test_reset_mid_track();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Recovers BCD digits from a multiplexed 7-segment display bus: the segment lines plus one-hot digit-select lines, as produced by our BCD-to-segment driver and digit scanner.
- This is the reverse path of the segment driver. It is used for loopback self-test and for reading an external scanned display back into the counter logic.
- It samples the bus, requires each (select, pattern) pair to be stable for a set number of cycles, then decodes the pattern to a BCD value plus decimal point for that digit slot.

Parameters:
- NUM_DIGITS, 4: number of scanned digit positions; range 1..8.
- STABLE_CYCLES, 4: consecutive identical samples required before commit; range 1..15.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- seg_in  input  8  raw segment lines, bit order {p,g,f,e,d,c,b,a}.
- sel_in  input  NUM_DIGITS  digit select, active-high, expected one-hot or all-zero.
- inv  input  1  0 = segments active-low (common anode, default); 1 = segments active-high (common cathode).
- bcd_out  output  4*NUM_DIGITS  decoded digit i in bits [4i+3:4i].
- dp_out  output  NUM_DIGITS  decimal-point state per digit; 1 = lit.
- valid  output  NUM_DIGITS  1 = the bcd_out field holds a decoded 0..9.
- upd_stb  output  1  one-cycle pulse on each successful or blank commit.
- upd_idx  output  3  digit index of the last commit.
- err  output  1  one-cycle pulse on an unrecognised pattern or a multi-hot select.

Behaviour:
- Reset (rst=1 at an edge):
  - bcd_out fields = 4'hF; dp_out = 0; valid = 0; upd_stb = 0; upd_idx = 0; err = 0.
  - FSM goes to IDLE and the input register clears. Reset mid-track discards the candidate.
- Input stage:
  - seg_in, sel_in and inv are registered once. No synchroniser beyond this; async sources are handled by the stability filter.
  - Normalisation: lit = inv ? seg : ~seg, giving 8 bits with 1 = segment on.
- Decode table (lit gfedcba -> value):
  - 0111111->0, 0000110->1, 1011011->2, 1001111->3, 1100110->4
  - 1101101->5, 1111101->6, 0000111->7, 1111111->8, 1101111->9
  - 0000000 -> blank.
  - Any other pattern -> unrecognised.
  - The dp bit is taken separately from lit[7] and does not affect the match.
- Sample classes: sel = 0 -> idle; sel one-hot -> digit sample with index = position of the set bit; sel >1 bit set -> illegal.
- FSM states IDLE, TRACK, LOCKED. A sample "matches" when registered sel, seg and inv all equal the held candidate.
  - IDLE:
    - digit sample -> capture candidate, cnt = 1, go to TRACK. If STABLE_CYCLES = 1, commit on this same edge and go to LOCKED.
    - illegal -> pulse err, stay IDLE.
  - TRACK:
    - match -> cnt+1; when the new cnt equals STABLE_CYCLES, commit on this edge and go to LOCKED.
    - mismatch with a digit sample -> recapture, cnt = 1.
    - mismatch with idle -> IDLE.
    - mismatch with illegal -> err pulse, IDLE.
  - LOCKED:
    - match -> hold; no repeat commit.
    - mismatch -> same handling as TRACK mismatch.
- Commit for candidate index k:
  - Digit 0..9: bcd field k = value, dp_out[k] = lit[7], valid[k] = 1, upd_stb = 1, upd_idx = k.
  - Blank: field k = 4'hF, dp_out[k] = lit[7], valid[k] = 0, upd_stb = 1, upd_idx = k.
  - Unrecognised: err = 1, valid[k] = 0; field and dp unchanged; upd_stb = 0.
- Latency:
  - Pins stable before edge N are registered at edge N and counted as sample 1 at edge N+1.
  - Commit outputs are visible after edge N+STABLE_CYCLES. Pins must hold through that edge.
- Pulses:
  - upd_stb and err are high exactly one cycle and are never both high.
  - Commits on other digits leave their fields untouched.
- cnt saturates at STABLE_CYCLES. A change of inv alone counts as a mismatch.

Test Plan:
- Reset value: assert rst 2 cycles -> bcd_out = 16'hFFFF, valid = 0, upd_stb = err = 0.
- Single-digit commit: inv = 0, sel = 4'b0010, seg = 8'b10100100 held 6 cycles.
  - Required: after edge N+4, field 1 = 2, valid = 4'b0010, dp_out[1] = 0.
  - Required: upd_stb high one cycle with upd_idx = 1; no second pulse while the input is held.
- Glitch filter: same digit held 3 cycles, then seg changes -> no commit. New pattern 8'b10010000 held 4 cycles -> field 1 = 9.
- Full scan loop: inv = 1, digits 0..3 driven with 8'b00000110, 8'b01111111, 8'b11101101 (dp lit), 8'b00000000, 5 cycles each with 1 idle cycle between.
  - Required: fields = {F, 5, 8, 1} (digit 3..0), valid = 4'b0111, dp_out = 4'b0100.
- Error paths:
  - sel = 4'b0110 -> err pulses once, no field change.
  - Valid sel with lit 0001001 held 4 cycles -> err pulse, valid bit cleared, field retained.
- Reset mid-operation: rst asserted at cnt = 3 -> outputs return to reset values, no commit. The candidate must be re-held a full STABLE_CYCLES after release before it commits.
